// File: rtl/uart_pkg.sv
// Framing constants and FSM encoding shared by the UART transmitter and receiver,
// so both ends of the link agree on bit timing and line levels.
package uart_pkg;

    localparam int   DEFAULT_OVERSAMPLE = 16;
    localparam int   DEFAULT_DATA_BITS  = 8;
    localparam logic LINE_IDLE          = 1'b1;
    localparam logic LINE_START         = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running OVERSAMPLE-cycle counter with synchronous clear; tc marks the
// last clkx16 cycle of a bit period.
module uart_bit_timer #(
    parameter int OVERSAMPLE = uart_pkg::DEFAULT_OVERSAMPLE
) (
    input  logic clkx16,
    input  logic reset,
    input  logic clear,
    output logic tc
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clkx16 or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, MSB first, with a one-entry holding register in front of
// the shift register so consecutive frames go out with no idle gap.
module uart_tx #(
    parameter int DATA_BITS  = uart_pkg::DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::DEFAULT_OVERSAMPLE,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clkx16,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 load,
    input  logic                 tx_en,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    import uart_pkg::*;

    localparam int IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int STOP_LEN = OVERSAMPLE * STOP_BITS;
    localparam int SC_W     = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [SC_W-1:0]  STOP_LAST = SC_W'(STOP_LEN - 1);

    uart_state_e          state;
    logic [DATA_BITS-1:0] hold_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 hold_valid;
    logic [IDX_W-1:0]     bit_idx;
    logic [SC_W-1:0]      stop_cnt;
    logic                 bit_tc;
    logic                 stop_end;
    logic                 transfer;
    logic                 timer_clear;

    // A frame may start from IDLE or straight out of the final stop cycle, which
    // is what makes back-to-back frames seamless.
    assign stop_end    = (state == STOP) && (stop_cnt == STOP_LAST);
    assign transfer    = hold_valid && tx_en && ((state == IDLE) || stop_end);
    assign timer_clear = (state == IDLE) || stop_end;
    assign ready       = ~hold_valid;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clkx16(clkx16),
        .reset (reset),
        .clear (timer_clear),
        .tc    (bit_tc)
    );

    always_ff @(posedge clkx16 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= LINE_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            hold_valid <= 1'b0;
            hold_reg   <= '0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            stop_cnt   <= '0;
        end else begin
            done <= stop_end;

            // Accept only while the holding register is empty, so it can never
            // coincide with a transfer out of it.
            if (load && !hold_valid) begin
                hold_reg   <= data;
                hold_valid <= 1'b1;
            end

            if (transfer) begin
                shift_reg  <= hold_reg;
                hold_valid <= 1'b0;
                state      <= START;
                tx         <= LINE_START;
                busy       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tx   <= LINE_IDLE;
                        busy <= 1'b0;
                    end
                    START: begin
                        if (bit_tc) begin
                            state   <= DATA;
                            bit_idx <= IDX_TOP;
                            tx      <= shift_reg[IDX_TOP];
                        end
                    end
                    DATA: begin
                        if (bit_tc) begin
                            if (bit_idx == '0) begin
                                state    <= STOP;
                                stop_cnt <= '0;
                                tx       <= LINE_IDLE;
                            end else begin
                                bit_idx <= bit_idx - IDX_ONE;
                                tx      <= shift_reg[bit_idx - IDX_ONE];
                            end
                        end
                    end
                    STOP: begin
                        if (stop_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= LINE_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
